// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port
// between NREQ writeback sources, plus a per-register busy scoreboard.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake, ready is one-hot grant
//   req_addr/req_data   packed per-requester dest address and data
//   iss_valid/addr      issue stage marks a destination pending
//   iss_ready           issue accepted (destination not busy)
//   rs1/rs2_addr/busy   scoreboard lookups for the issue stage
//   rf_wen/waddr/wdata  registered register-file write port
//
// Optional feature macro RF_WB_ARB_BYPASS_EN adds rs1_fwd/rs2_fwd and
// rs1_fwd_data/rs2_fwd_data, forwarding the write in its commit cycle.

module rf_wb_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_addr,
  output logic                       iss_ready,
  input  logic [ADDR_WIDTH-1:0]      rs1_addr,
  output logic                       rs1_busy,
  input  logic [ADDR_WIDTH-1:0]      rs2_addr,
  output logic                       rs2_busy,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata
`ifdef RF_WB_ARB_BYPASS_EN
  ,
  output logic                       rs1_fwd,
  output logic [DATA_WIDTH-1:0]      rs1_fwd_data,
  output logic                       rs2_fwd,
  output logic [DATA_WIDTH-1:0]      rs2_fwd_data
`endif
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREG-1:0]       busy_q, busy_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  found;
  logic                  fire;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         cand;
  logic                  hit;
  int                    s;
  int                    s_nxt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  iss_fire;
  logic                  rs1_hit, rs2_hit;

  // Scan candidates rr, rr+1, ... modulo NREQ; first valid wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    hit     = 1'b0;
    s       = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(rr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      cand = PW'(s);
      hit  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (cand == PW'(i)) hit = req_valid[i];
      end
      if (!found && hit) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign fire = found & ~rst;

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        req_ready[i] = fire;
        sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer moves past the winner; holds when nothing is granted.
  always_comb begin
    rr_d  = rr_q;
    s_nxt = 0;
    if (fire) begin
      s_nxt = int'(gnt_idx) + 1;
      if (s_nxt >= NREQ) s_nxt = 0;
      rr_d = PW'(s_nxt);
    end
  end

  // Writes to reg 0 complete the handshake but never reach the RF.
  always_comb begin
    wen_d   = fire & (sel_addr != '0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (fire) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
  end

  assign iss_ready = ~rst & (~busy_q[iss_addr] | (iss_addr == '0));
  assign iss_fire  = iss_valid & iss_ready & (iss_addr != '0);

  // Clear on commit first so a same-cycle issue to that reg wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (iss_fire) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

`ifdef RF_WB_ARB_BYPASS_EN
  assign rs1_hit      = wen_q & (waddr_q == rs1_addr) & (rs1_addr != '0);
  assign rs2_hit      = wen_q & (waddr_q == rs2_addr) & (rs2_addr != '0);
  assign rs1_fwd      = rs1_hit;
  assign rs2_fwd      = rs2_hit;
  assign rs1_fwd_data = wdata_q;
  assign rs2_fwd_data = wdata_q;
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  assign rs1_busy = busy_q[rs1_addr] & (rs1_addr != '0) & ~rs1_hit;
  assign rs2_busy = busy_q[rs2_addr] & (rs2_addr != '0) & ~rs2_hit;

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      rr_q    <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NREQ=2, 5-bit addr, 32-bit data).
// Build with RF_WB_ARB_BYPASS_EN to exercise the forwarding outputs.

module tb_rf_wb_arbiter;

`ifdef RF_WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef RF_WB_ARB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int n_chk = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.NREQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RF_WB_ARB_BYPASS_EN
    ,
    .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    req_data  = {32'hB0B0_0004, 32'hA0A0_0003};
    iss_valid = 1'b0;
    iss_addr  = 5'd0;
    rs1_addr  = 5'd0;
    rs2_addr  = 5'd0;

    // Reset
    tick();
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
      chk("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    end
    tick();
    chk("rst2_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst2_ready", {30'd0, req_ready}, 32'd0);

    // Round-robin with both requesters valid
    rst = 1'b0;
    #1;
    chk("rr_first", {30'd0, req_ready}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rr_wen", {31'd0, rf_wen}, 32'd1);
      chk("rr_waddr", {27'd0, rf_waddr}, (n % 2) ? 32'd4 : 32'd3);
      chk("rr_wdata", rf_wdata,
          (n % 2) ? 32'hB0B0_0004 : 32'hA0A0_0003);
      chk("rr_ready", {30'd0, req_ready}, (n % 2) ? 32'd1 : 32'd2);
    end
    req_valid = 2'b00;
    #1;
    chk("idle_ready", {30'd0, req_ready}, 32'd0);
    tick();
    chk("idle_wen", {31'd0, rf_wen}, 32'd0);

    // Scoreboard: issue 7, LSU commits 7
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    rs1_addr  = 5'd7;
    #1;
    chk("sb_iss_ready0", {31'd0, iss_ready}, 32'd1);
    chk("sb_busy_pre", {31'd0, rs1_busy}, 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("sb_busy_set", {31'd0, rs1_busy}, 32'd1);
    chk("sb_iss_blocked", {31'd0, iss_ready}, 32'd0);
    req_valid = 2'b10;
    req_addr  = {5'd7, 5'd0};
    req_data  = {32'hDEAD_BEEF, 32'h0};
    #1;
    chk("sb_grant_lsu", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    #1;
    chk("sb_wen", {31'd0, rf_wen}, 32'd1);
    chk("sb_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("sb_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("sb_busy_commit", {31'd0, rs1_busy}, BYP ? 32'd0 : 32'd1);
    tick();
    chk("sb_wen_off", {31'd0, rf_wen}, 32'd0);
    chk("sb_busy_clr", {31'd0, rs1_busy}, 32'd0);
    chk("sb_iss_ok", {31'd0, iss_ready}, 32'd1);

    // Zero register
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd0};
    req_data  = {32'h0, 32'h0000_1234};
    #1;
    chk("z_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("z_wen", {31'd0, rf_wen}, 32'd0);
    iss_valid = 1'b1;
    iss_addr  = 5'd0;
    rs1_addr  = 5'd0;
    #1;
    chk("z_iss_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("z_rs1_busy", {31'd0, rs1_busy}, 32'd0);

    // Collision: commit 5 and issue 5 in one cycle
    req_valid = 2'b10;
    req_addr  = {5'd5, 5'd0};
    req_data  = {32'h0000_0AAA, 32'h0};
    tick();
    req_valid = 2'b00;
    #1;
    chk("col_wen", {31'd0, rf_wen}, 32'd1);
    chk("col_waddr", {27'd0, rf_waddr}, 32'd5);
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    #1;
    chk("col_iss_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    rs2_addr  = 5'd5;
    #1;
    chk("col_busy", {31'd0, rs2_busy}, 32'd1);
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd5};
    tick();
    req_valid = 2'b00;
    tick();
    chk("col_busy_clr", {31'd0, rs2_busy}, 32'd0);

    // Commit to 9 while rs2 looks it up
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    tick();
    iss_valid = 1'b0;
    rs2_addr  = 5'd9;
    rs1_addr  = 5'd0;
    #1;
    chk("byp_busy_pre", {31'd0, rs2_busy}, 32'd1);
    req_valid = 2'b10;
    req_addr  = {5'd9, 5'd0};
    req_data  = {32'h0000_0055, 32'h0};
    tick();
    req_valid = 2'b00;
    #1;
    chk("byp_wen", {31'd0, rf_wen}, 32'd1);
    chk("byp_rs2_busy", {31'd0, rs2_busy}, BYP ? 32'd0 : 32'd1);
`ifdef RF_WB_ARB_BYPASS_EN
    chk("byp_rs2_fwd", {31'd0, rs2_fwd}, 32'd1);
    chk("byp_rs2_data", rs2_fwd_data, 32'h0000_0055);
    chk("byp_rs1_fwd", {31'd0, rs1_fwd}, 32'd0);
`endif
    tick();
    chk("byp_busy_clr", {31'd0, rs2_busy}, 32'd0);
`ifdef RF_WB_ARB_BYPASS_EN
    chk("byp_fwd_off", {31'd0, rs2_fwd}, 32'd0);
`endif

    // Reset mid-transfer; pointer and busy must clear
    iss_valid = 1'b1;
    iss_addr  = 5'd12;
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd0};
    tick();
    iss_valid = 1'b0;
    req_valid = 2'b00;
    rs1_addr  = 5'd12;
    #1;
    chk("mr_busy12", {31'd0, rs1_busy}, 32'd1);
    rst       = 1'b1;
    req_valid = 2'b11;
    req_addr  = {5'd6, 5'd6};
    req_data  = {32'h6666_6666, 32'h6666_6666};
    #1;
    chk("mr_ready", {30'd0, req_ready}, 32'd0);
    tick();
    chk("mr_wen", {31'd0, rf_wen}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_ptr", {30'd0, req_ready}, 32'd1);
    chk("mr_busy_clr", {31'd0, rs1_busy}, 32'd0);
    req_valid = 2'b00;
    tick();
    chk("mr_wen2", {31'd0, rf_wen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
